alu_cmd_sequencer: RTL and testbench

//  Upstream issue stage for the 4-bit ALU (op 00 SRA, 01 SRL, 10 SUB, 11 ADD).
//  - Accepts one command per valid/ready handshake and holds operands stable for one EXEC cycle.
//  - Drives the ALU input ports from registers, captures the ALU result, and presents it on a

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_cmd_sequencer_if.sv | 42 ++++
 rtl/alu_cmd_sequencer.sv | 91 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: op codes, default widths and FSM encoding.
package alu_pkg;

    localparam int DW_DEF   = 4;
    localparam int SW_DEF   = 2;
    localparam int CNTW_DEF = 8;

    localparam logic [1:0] ALU_SRA = 2'b00;
    localparam logic [1:0] ALU_SRL = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-side and result signals of the ALU issue stage.
interface alu_cmd_sequencer_if
    import alu_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int SW   = SW_DEF,
    parameter int CNTW = CNTW_DEF
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [DW-1:0]   cmd_a;
    logic [DW-1:0]   cmd_b;
    logic [SW-1:0]   cmd_c;
    logic            cmd_chain;
    logic            acc_clr;
    logic [DW-1:0]   alu_inA;
    logic [DW-1:0]   alu_inB;
    logic [SW-1:0]   alu_inC;
    logic [1:0]      alu_op;
    logic [DW-1:0]   alu_ans;
    logic            res_valid;
    logic            res_ready;
    logic [DW-1:0]   res_data;
    logic [CNTW-1:0] op_count;

    // Master is the surrounding environment: command source, result sink and the ALU itself.
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, cmd_chain, acc_clr,
        output alu_ans, res_ready,
        input  cmd_ready, alu_inA, alu_inB, alu_inC, alu_op,
        input  res_valid, res_data, op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, cmd_chain, acc_clr,
        input  alu_ans, res_ready,
        output cmd_ready, alu_inA, alu_inB, alu_inC, alu_op,
        output res_valid, res_data, op_count
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit ALU: accepts a command, holds operands for one EXEC cycle,
// captures the result into an accumulator and offers it on a valid/ready port.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int SW   = SW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_cmd_sequencer_if.slave   bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_consume;

    logic [DW-1:0]   r_alu_a;
    logic [DW-1:0]   r_alu_b;
    logic [SW-1:0]   r_alu_c;
    logic [1:0]      r_alu_op;
    logic [DW-1:0]   r_res_data;
    logic [DW-1:0]   r_acc;
    logic            r_res_valid;
    logic [CNTW-1:0] r_op_count;

    assign w_accept  = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_consume = (r_state == S_DONE) && bus.res_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_DONE;
            S_DONE:  if (bus.res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_c     <= '0;
            r_alu_op    <= '0;
            r_res_data  <= '0;
            r_acc       <= '0;
            r_res_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_accept) begin
                r_alu_op <= bus.cmd_op;
                r_alu_a  <= bus.cmd_chain ? r_acc : bus.cmd_a;
                r_alu_b  <= bus.cmd_b;
                r_alu_c  <= bus.cmd_c;
            end
            // The EXEC capture takes priority over a simultaneous accumulator clear.
            if (r_state == S_EXEC) begin
                r_res_data  <= bus.alu_ans;
                r_acc       <= bus.alu_ans;
                r_res_valid <= 1'b1;
            end else if (bus.acc_clr) begin
                r_acc <= '0;
            end
            if (w_consume) begin
                r_res_valid <= 1'b0;
                r_op_count  <= r_op_count + CNTW'(1);
            end
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.alu_inA   = r_alu_a;
    assign bus.alu_inB   = r_alu_b;
    assign bus.alu_inC   = r_alu_c;
    assign bus.alu_op    = r_alu_op;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 4-bit ALU as sibling.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.DW(4), .SW(2), .CNTW(8)) bus ();

    alu_cmd_sequencer #(.DW(4), .SW(2), .CNTW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic signed [3:0] w_sra;
    always_comb begin
        w_sra       = $signed(bus.alu_inA) >>> bus.alu_inC;
        bus.alu_ans = 4'h0;
        case (bus.alu_op)
            ALU_SRA: bus.alu_ans = w_sra;
            ALU_SRL: bus.alu_ans = bus.alu_inA >> bus.alu_inC;
            ALU_SUB: bus.alu_ans = bus.alu_inA - bus.alu_inB;
            default: bus.alu_ans = bus.alu_inA + bus.alu_inB;
        endcase
    end

    int         n_vec = 0;
    int         n_bad = 0;
    int         exp_count = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_result: got %0h expected none", bus.res_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("res_data", {28'h0, bus.res_data}, {28'h0, mon_exp});
            end
        end
    end

    // clr_mode: 0 none, 1 acc_clr on the accept edge, 2 acc_clr on the EXEC capture edge.
    // keep=0 leaves the command in EXEC and returns without expecting a result.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] c, input logic chain, input logic [3:0] exp,
                          input int clr_mode, input bit keep);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("cmd_ready_timeout", 32'd0, 32'd1);
        if (keep) exp_q.push_back(exp);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_c     = c;
        bus.cmd_chain = chain;
        bus.acc_clr   = (clr_mode == 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_chain = 1'b0;
        bus.acc_clr   = 1'b0;
        check("exec_ready_valid", {30'h0, bus.cmd_ready, bus.res_valid}, 32'd0);
        if (keep) begin
            bus.acc_clr = (clr_mode == 2);
            @(posedge clk);
            #1;
            bus.acc_clr = 1'b0;
            check("res_valid_latency", {31'h0, bus.res_valid}, 32'd1);
            if (bus.res_ready) begin
                @(posedge clk);
                #1;
                exp_count = (exp_count + 1) % 256;
                check("op_count", {24'h0, bus.op_count}, exp_count);
                check("res_valid_drop", {31'h0, bus.res_valid}, 32'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 4'h0;
        bus.cmd_b     = 4'h0;
        bus.cmd_c     = 2'b00;
        bus.cmd_chain = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'd1);
        check("rst_res_valid", {31'h0, bus.res_valid}, 32'd0);
        check("rst_res_data", {28'h0, bus.res_data}, 32'd0);
        check("rst_op_count", {24'h0, bus.op_count}, 32'd0);
        check("rst_alu_regs", {20'h0, bus.alu_inA, bus.alu_inB, bus.alu_inC, bus.alu_op}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // res_ready with nothing pending must not count
        repeat (3) @(posedge clk);
        #1;
        check("idle_res_ready", {24'h0, bus.op_count}, 32'd0);

        do_cmd(ALU_ADD, 4'd7, 4'd9, 2'd0, 1'b0, 4'h0, 0, 1'b1);
        check("alu_op_held", {30'h0, bus.alu_op}, {30'h0, ALU_ADD});

        do_cmd(ALU_SRA, 4'b1000, 4'd0, 2'd2, 1'b0, 4'b1110, 0, 1'b1);
        do_cmd(ALU_SRL, 4'b1000, 4'd0, 2'd2, 1'b0, 4'b0010, 0, 1'b1);
        do_cmd(ALU_SUB, 4'd3, 4'd5, 2'd0, 1'b0, 4'hE, 0, 1'b1);
        do_cmd(ALU_ADD, 4'd9, 4'd1, 2'd0, 1'b1, 4'hF, 0, 1'b1);

        // Back-pressure: result held, second command waits
        bus.res_ready = 1'b0;
        do_cmd(ALU_ADD, 4'd1, 4'd2, 2'd0, 1'b0, 4'h3, 0, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = ALU_ADD;
        bus.cmd_a     = 4'd4;
        bus.cmd_b     = 4'd4;
        bus.cmd_c     = 2'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_res_data", {28'h0, bus.res_data}, 32'h3);
            check("stall_cmd_ready", {30'h0, bus.cmd_ready, bus.res_valid}, 32'd1);
        end
        exp_q.push_back(4'h8);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_count = (exp_count + 1) % 256;
        check("stall_op_count", {24'h0, bus.op_count}, exp_count);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("stall_accept", {31'h0, bus.cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("stall_second_valid", {31'h0, bus.res_valid}, 32'd1);
        @(posedge clk);
        #1;
        exp_count = (exp_count + 1) % 256;
        check("stall_second_count", {24'h0, bus.op_count}, exp_count);

        // Reset while a command sits in EXEC
        do_cmd(ALU_ADD, 4'd3, 4'd3, 2'd0, 1'b0, 4'h0, 0, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_res_valid", {31'h0, bus.res_valid}, 32'd0);
        check("midrst_cmd_ready", {31'h0, bus.cmd_ready}, 32'd1);
        check("midrst_op_count", {24'h0, bus.op_count}, 32'd0);
        exp_count = 0;
        @(negedge clk);
        reset = 1'b0;
        do_cmd(ALU_ADD, 4'd9, 4'd2, 2'd0, 1'b1, 4'h2, 0, 1'b1);

        // Counter wrap: start from zero, 256 results return it to zero
        reset = 1'b1;
        #1;
        exp_count = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            do_cmd(ALU_ADD, 4'(i), 4'd3, 2'd0, 1'b0, 4'(i + 3), 0, 1'b1);
        end
        check("wrap_op_count", {24'h0, bus.op_count}, 32'd0);

        @(negedge clk);
        bus.acc_clr = 1'b1;
        @(negedge clk);
        bus.acc_clr = 1'b0;
        do_cmd(ALU_ADD, 4'd9, 4'd5, 2'd0, 1'b1, 4'h5, 0, 1'b1);
        do_cmd(ALU_ADD, 4'd9, 4'd1, 2'd0, 1'b1, 4'h6, 1, 1'b1);
        do_cmd(ALU_ADD, 4'd9, 4'd0, 2'd0, 1'b1, 4'h6, 0, 1'b1);
        do_cmd(ALU_ADD, 4'd2, 4'd2, 2'd0, 1'b0, 4'h4, 2, 1'b1);
        do_cmd(ALU_ADD, 4'd9, 4'd1, 2'd0, 1'b1, 4'h5, 0, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
